// File: rtl/jtag_tap_core.sv
// jtag_tap_core: IEEE 1149.1 TAP with IR, BYPASS, IDCODE and USER registers.
// Shift registers move on rising tck; tdo, ir and user updates on falling tck.
module jtag_tap_core #(
  parameter int                  IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VAL   = 32'h1234_5671,
  parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = 4'h1,
  parameter logic [IR_WIDTH-1:0] USER_INSTR   = 4'h8,
  parameter int                  USER_WIDTH   = 8
) (
  input  logic                  tck,
  input  logic                  trst,
  input  logic                  tms,
  input  logic                  tdi,
  output logic                  tdo,
  output logic                  tdo_en,
  output logic [3:0]            state,
  output logic [IR_WIDTH-1:0]   ir,
  output logic                  capture_dr,
  output logic                  shift_dr,
  output logic                  update_dr,
  output logic                  capture_ir,
  output logic                  shift_ir,
  output logic                  update_ir,
  output logic                  tlr,
  input  logic [USER_WIDTH-1:0] user_dr_in,
  output logic [USER_WIDTH-1:0] user_dr_out,
  output logic                  user_update
);

  typedef enum logic [3:0] {
    TLR    = 4'h0, RTI    = 4'h1, SEL_DR = 4'h2, CAP_DR = 4'h3,
    SH_DR  = 4'h4, EX1_DR = 4'h5, EX2_DR = 4'h6, UPD_DR = 4'h7,
    PAU_DR = 4'h8, SEL_IR = 4'h9, CAP_IR = 4'hA, SH_IR  = 4'hB,
    EX1_IR = 4'hC, EX2_IR = 4'hD, UPD_IR = 4'hE, PAU_IR = 4'hF
  } tap_e;

  localparam logic [IR_WIDTH-1:0] IR_CAP = {{(IR_WIDTH-1){1'b0}}, 1'b1};

  tap_e                  st;
  tap_e                  st_nx;
  logic [IR_WIDTH-1:0]   ir_sr;
  logic                  bypass_sr;
  logic [31:0]           idcode_sr;
  logic [USER_WIDTH-1:0] user_sr;
  logic                  sel_id;
  logic                  sel_user;
  logic                  dr_lsb;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) st <= TLR;
    else       st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      TLR:    st_nx = tms ? TLR    : RTI;
      RTI:    st_nx = tms ? SEL_DR : RTI;
      SEL_DR: st_nx = tms ? SEL_IR : CAP_DR;
      CAP_DR: st_nx = tms ? EX1_DR : SH_DR;
      SH_DR:  st_nx = tms ? EX1_DR : SH_DR;
      EX1_DR: st_nx = tms ? UPD_DR : PAU_DR;
      PAU_DR: st_nx = tms ? EX2_DR : PAU_DR;
      EX2_DR: st_nx = tms ? UPD_DR : SH_DR;
      UPD_DR: st_nx = tms ? SEL_DR : RTI;
      SEL_IR: st_nx = tms ? TLR    : CAP_IR;
      CAP_IR: st_nx = tms ? EX1_IR : SH_IR;
      SH_IR:  st_nx = tms ? EX1_IR : SH_IR;
      EX1_IR: st_nx = tms ? UPD_IR : PAU_IR;
      PAU_IR: st_nx = tms ? EX2_IR : PAU_IR;
      EX2_IR: st_nx = tms ? UPD_IR : SH_IR;
      UPD_IR: st_nx = tms ? SEL_DR : RTI;
    endcase
  end

  always_comb begin
    sel_id   = 1'b0;
    sel_user = 1'b0;
    unique case (1'b1)
      (ir == IDCODE_INSTR): sel_id   = 1'b1;
      (ir == USER_INSTR):   sel_user = 1'b1;
      default: ;
    endcase
  end

  assign dr_lsb = sel_id   ? idcode_sr[0] :
                  sel_user ? user_sr[0]   : bypass_sr;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_sr     <= '0;
      bypass_sr <= 1'b0;
      idcode_sr <= '0;
      user_sr   <= '0;
    end else begin
      if (st == CAP_IR)     ir_sr <= IR_CAP;
      else if (st == SH_IR) ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
      if (st == CAP_DR) begin
        if (sel_id)        idcode_sr <= IDCODE_VAL;
        else if (sel_user) user_sr   <= user_dr_in;
        else               bypass_sr <= 1'b0;
      end else if (st == SH_DR) begin
        if (sel_id)
          idcode_sr <= {tdi, idcode_sr[31:1]};
        else if (sel_user)
          // shift form that stays legal for a one-bit USER register
          user_sr <= (user_sr >> 1) |
                     (USER_WIDTH'(tdi) << (USER_WIDTH-1));
        else
          bypass_sr <= tdi;
      end
    end
  end

  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      ir          <= IDCODE_INSTR;
      user_dr_out <= '0;
      user_update <= 1'b0;
      tdo         <= 1'b0;
      tdo_en      <= 1'b0;
    end else begin
      user_update <= 1'b0;
      tdo         <= 1'b0;
      tdo_en      <= 1'b0;
      if (st == UPD_IR)   ir <= ir_sr;
      else if (st == TLR) ir <= IDCODE_INSTR;
      if (st == UPD_DR && sel_user) begin
        user_dr_out <= user_sr;
        user_update <= 1'b1;
      end
      if (st == SH_IR) begin
        tdo    <= ir_sr[0];
        tdo_en <= 1'b1;
      end else if (st == SH_DR) begin
        tdo    <= dr_lsb;
        tdo_en <= 1'b1;
      end
    end
  end

  assign state      = st;
  assign capture_dr = (st == CAP_DR);
  assign shift_dr   = (st == SH_DR);
  assign update_dr  = (st == UPD_DR);
  assign capture_ir = (st == CAP_IR);
  assign shift_ir   = (st == SH_IR);
  assign update_ir  = (st == UPD_IR);
  assign tlr        = (st == TLR);

endmodule

// File: tb/tb_jtag_tap_core.sv
// tb_jtag_tap_core: FSM walk table plus scoreboarded IR/DR scans,
// pause/resume, TLR via tms and trst mid-shift.
module tb_jtag_tap_core;

  logic       tck  = 1'b0;
  logic       trst = 1'b0;
  logic       tms  = 1'b1;
  logic       tdi  = 1'b0;
  logic       tdo, tdo_en;
  logic [3:0] state, ir;
  logic       capture_dr, shift_dr, update_dr;
  logic       capture_ir, shift_ir, update_ir, tlr;
  logic [7:0] user_dr_in = 8'h00;
  logic [7:0] user_dr_out;
  logic       user_update;

  always #5 tck = ~tck;

  jtag_tap_core dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi),
    .tdo(tdo), .tdo_en(tdo_en), .state(state), .ir(ir),
    .capture_dr(capture_dr), .shift_dr(shift_dr),
    .update_dr(update_dr), .capture_ir(capture_ir),
    .shift_ir(shift_ir), .update_ir(update_ir), .tlr(tlr),
    .user_dr_in(user_dr_in), .user_dr_out(user_dr_out),
    .user_update(user_update)
  );

  typedef struct packed {
    logic       tms;
    logic       tdi;
    logic [3:0] st;
    logic       en;
  } vec_t;

  vec_t fv[$];
  logic sb[$];
  int   nvec = 0;
  int   nbad = 0;
  int   upd_cnt = 0;
  int   cnt0;

  always @(posedge user_update) upd_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  task automatic add(input logic m, input logic [3:0] s);
    vec_t v;
    v.tms = m;
    v.tdi = 1'b0;
    v.st  = s;
    v.en  = (s == 4'h4) || (s == 4'hB);
    fv.push_back(v);
  endtask

  // shifts n bits LSB-first; last bit leaves with tms=1
  task automatic shift(input logic [31:0] din, input logic [31:0] dexp,
                       input int n);
    logic e;
    for (int i = 0; i < n; i++) sb.push_back(dexp[i]);
    for (int i = 0; i < n; i++) begin
      chk("shift_en", 32'(tdo_en), 32'h1);
      e = sb.pop_front();
      chk("shift_tdo", 32'(tdo), 32'(e));
      step(i == n - 1, din[i]);
    end
    chk("exit_en", 32'(tdo_en), 32'h0);
  endtask

  task automatic ir_scan(input logic [3:0] v);
    step(1, 0);
    step(1, 0);
    step(0, 0);
    chk("cap_ir_st", 32'(state), 32'hA);
    step(0, 0);
    shift(32'(v), 32'h1, 4);
    step(1, 0);
    chk("ir_load", 32'(ir), 32'(v));
    step(0, 0);
  endtask

  task automatic dr_enter();
    step(1, 0);
    step(0, 0);
    chk("cap_dr_en", 32'(tdo_en), 32'h0);
    step(0, 0);
    chk("sh_dr_st", 32'(state), 32'h4);
  endtask

  task automatic do_reset();
    trst = 1'b0;
    tms  = 1'b1;
    tdi  = 1'b0;
    @(negedge tck);
    #1;
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_ir", 32'(ir), 32'h1);
    chk("rst_tdo", 32'(tdo), 32'h0);
    chk("rst_tdo_en", 32'(tdo_en), 32'h0);
    chk("rst_udo", 32'(user_dr_out), 32'h0);
    chk("rst_upd", 32'(user_update), 32'h0);
    trst = 1'b1;
  endtask

  initial begin
    do_reset();
    repeat (5) step(1, 0);
    chk("tlr_state", 32'(state), 32'h0);
    chk("tlr_ir", 32'(ir), 32'h1);
    chk("tlr_en", 32'(tdo_en), 32'h0);
    chk("tlr_strobe", 32'(tlr), 32'h1);
    step(0, 0);
    chk("rti_state", 32'(state), 32'h1);

    add(0, 4'h1); add(1, 4'h2); add(1, 4'h9); add(1, 4'h0);
    add(0, 4'h1); add(1, 4'h2); add(0, 4'h3); add(1, 4'h5);
    add(0, 4'h8); add(0, 4'h8); add(1, 4'h6); add(0, 4'h4);
    add(0, 4'h4); add(1, 4'h5); add(1, 4'h7); add(1, 4'h2);
    add(0, 4'h3); add(0, 4'h4); add(1, 4'h5); add(0, 4'h8);
    add(1, 4'h6); add(1, 4'h7); add(0, 4'h1); add(1, 4'h2);
    add(1, 4'h9); add(0, 4'hA); add(1, 4'hC); add(0, 4'hF);
    add(1, 4'hD); add(0, 4'hB); add(1, 4'hC); add(1, 4'hE);
    add(1, 4'h2); add(1, 4'h9); add(0, 4'hA); add(0, 4'hB);
    add(1, 4'hC); add(0, 4'hF); add(0, 4'hF); add(1, 4'hD);
    add(1, 4'hE); add(0, 4'h1); add(1, 4'h2); add(1, 4'h9);
    add(1, 4'h0); add(1, 4'h0); add(1, 4'h0); add(0, 4'h1);
    for (int i = 0; i < fv.size(); i++) begin
      step(fv[i].tms, fv[i].tdi);
      chk("walk_state", 32'(state), 32'(fv[i].st));
      chk("walk_en", 32'(tdo_en), 32'(fv[i].en));
    end
    chk("walk_ir", 32'(ir), 32'h1);

    dr_enter();
    shift(32'h0, 32'h1234_5671, 32);
    step(1, 0);
    step(0, 0);

    ir_scan(4'hF);
    dr_enter();
    shift(32'hD, 32'hA, 4);
    step(1, 0);
    step(0, 0);

    ir_scan(4'h8);
    user_dr_in = 8'hA5;
    cnt0 = upd_cnt;
    dr_enter();
    shift(32'h3C, 32'hA5, 8);
    chk("udo_pre", 32'(user_dr_out), 32'h0);
    step(1, 0);
    chk("upd_pulse", 32'(user_update), 32'h1);
    chk("udo_user", 32'(user_dr_out), 32'h3C);
    step(0, 0);
    chk("upd_low", 32'(user_update), 32'h0);
    chk("upd_count", 32'(upd_cnt), 32'(cnt0 + 1));

    user_dr_in = 8'h5A;
    dr_enter();
    shift(32'hC, 32'hA, 4);
    for (int i = 0; i < 3; i++) begin
      step(0, 0);
      chk("pause_st", 32'(state), 32'h8);
      chk("pause_en", 32'(tdo_en), 32'h0);
    end
    step(1, 0);
    chk("ex2_st", 32'(state), 32'h6);
    step(0, 0);
    chk("resume_st", 32'(state), 32'h4);
    shift(32'h3, 32'h5, 4);
    step(1, 0);
    chk("udo_pause", 32'(user_dr_out), 32'h3C);
    step(0, 0);
    chk("upd_count2", 32'(upd_cnt), 32'(cnt0 + 2));

    repeat (5) step(1, 0);
    chk("tms_tlr_st", 32'(state), 32'h0);
    chk("tms_tlr_ir", 32'(ir), 32'h1);
    chk("tms_tlr_udo", 32'(user_dr_out), 32'h3C);
    step(0, 0);

    do_reset();
    step(0, 0);
    ir_scan(4'h8);
    user_dr_in = 8'hFF;
    cnt0 = upd_cnt;
    dr_enter();
    repeat (3) step(0, 1);
    trst = 1'b0;
    #2;
    chk("trst_st", 32'(state), 32'h0);
    chk("trst_ir", 32'(ir), 32'h1);
    chk("trst_udo", 32'(user_dr_out), 32'h0);
    chk("trst_en", 32'(tdo_en), 32'h0);
    @(negedge tck);
    #1;
    trst = 1'b1;
    step(1, 0);
    chk("trst_upd", 32'(upd_cnt), 32'(cnt0));
    chk("trst_st2", 32'(state), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
